// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, iteration index
// supplied by an external counter that this block enables while running.
module cordic_rot_iter #(
  parameter int Width = 16,
  parameter int Iters = 16,
  parameter int IterW = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [Width-1:0] x_i,
  input  logic signed [Width-1:0] y_i,
  input  logic signed [Width-1:0] z_i,
  input  logic [IterW-1:0]        iter_i,
  input  logic                    last_i,
  output logic                    cnt_ena_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [Width-1:0] x_o,
  output logic signed [Width-1:0] y_o,
  output logic signed [Width-1:0] z_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // round(atan(2^-i) * 2^(Width-2)); series evaluated in Q.60 integer math so
  // the table elaborates without any real-number support.
  function automatic int atan_fx(input int i);
    longint acc;
    longint term;
    int     sh;
    int     s;
    acc = 64'sh0C90FDAA22168C23; // pi/4 in Q.60
    if (i != 0) begin
      acc = 0;
      for (int k = 0; k < 32; k++) begin
        sh = 60 - i * (2 * k + 1);
        if (sh >= 0) begin
          term = (64'sd1 <<< sh) / longint'(2 * k + 1);
          acc  = (k % 2 == 0) ? acc + term : acc - term;
        end
      end
    end
    s = 60 - (Width - 2);
    return int'((acc + (64'sd1 <<< (s - 1))) >>> s);
  endfunction

  logic signed [Width-1:0] atan_tbl [2**IterW];

  for (genvar g = 0; g < 2**IterW; g++) begin : g_atan
    if (g < Iters) begin : g_val
      localparam int AtanVal = atan_fx(g);
      assign atan_tbl[g] = AtanVal[Width-1:0];
    end else begin : g_zero
      assign atan_tbl[g] = '0;
    end
  end

  state_e                  state_q, state_d;
  logic signed [Width-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [Width-1:0] x_sh, y_sh, atan_sel;

  assign x_sh     = x_q >>> iter_i;
  assign y_sh     = y_q >>> iter_i;
  assign atan_sel = atan_tbl[iter_i];

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    in_ready_o  = 1'b0;
    cnt_ena_o   = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          x_d     = x_i;
          y_d     = y_i;
          z_d     = z_i;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_ena_o = 1'b1;
        // d = +1 while the residual angle is non-negative
        if (!z_q[Width-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_sel;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_sel;
        end
        if (last_i) state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign z_o = z_q;

endmodule

// File: doc/cordic_rot_iter.md
# cordic_rot_iter

Iterative rotation-mode CORDIC engine for the CORDIC IP. It accepts one (x, y, z) operand set over a valid/ready handshake and runs one micro-rotation per clock. The iteration index comes from the shared iteration counter (`counter`): this block drives the counter's enable and consumes its count and terminal tick. The result is presented over a second valid/ready handshake to the downstream gain/output stage.

## Interface

Parameters:
- Width, 16: data width of x, y, z; signed two's complement, Q2.(Width-2); z in radians.
- Iters, 16: micro-rotations per operation; must satisfy 1 ≤ Iters ≤ Width; counter max_i is tied to Iters.
- IterW, 5: width of iter_i; must satisfy 2^IterW ≥ Iters.

Ports:
- clk_i  in  1  clock; reset rst_i, asynchronous, active-high
- rst_i  in  1  asynchronous active-high reset
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  block can accept operands
- x_i, y_i, z_i  in  Width each  operands, signed
- iter_i  in  IterW  current iteration index, from counter cnt_o
- last_i  in  1  final iteration flag, from counter tick_o
- cnt_ena_o  out  1  iteration counter enable
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- x_o, y_o, z_o  out  Width each  result registers, signed

## Operation

- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE
  - in_ready_o = 1.
  - On in_valid_i: register x_i, y_i, z_i into x_o, y_o, z_o, then go to RUN.
- RUN
  - cnt_ena_o = 1.
  - Each cycle applies iteration i = iter_i, with d = +1 if z_o ≥ 0, else -1:
    - x ← x − d·(y >>> i)
    - y ← y + d·(x >>> i)
    - z ← z − d·atan_i
    - All three updates use the old register values.
  - When last_i = 1, apply that iteration, then go to DONE.
- DONE
  - out_valid_o = 1; x_o, y_o, z_o are held.
  - On out_ready_i, go to IDLE.
- in_ready_o is 1 only in IDLE. in_valid_i is ignored in RUN and DONE. No overlap of operations.
- atan table:
  - atan_i = round(atan(2^-i)·2^(Width-2)) for i = 0..Iters-1, built at elaboration.
  - Width=16 values: 12868, 7596, 4014, 2037, …
  - Index i ≥ Iters reads 0.
- Arithmetic:
  - `>>>` is an arithmetic shift.
  - Sums wrap modulo 2^Width; no saturation.
  - No gain compensation. The output vector is scaled by K ≈ 1.6468.
  - Caller guarantees |(x_i, y_i)| ≤ 1.0 and |z_i| ≤ π/2, so results fit in Q2.(Width-2).
- The counter wraps to 0 on the final enabled tick. iter_i is therefore 0 at every RUN entry; the block relies on this and does not check it.
- Simultaneous in_valid_i and out_ready_i in DONE: the return to IDLE happens first. The new operand is accepted no earlier than the next cycle.

## Timing

- Reset values:
  - in_ready_o = 1 (state IDLE)
  - out_valid_o = 0, cnt_ena_o = 0
  - x_o = y_o = z_o = 0
- Input handshake at edge t:
  - Iteration updates occur at edges t+1 … t+Iters.
  - out_valid_o rises after edge t+Iters.
- Output handshake at edge u: in_ready_o = 1 after edge u.
- Minimum operation period: Iters+2 cycles.
- cnt_ena_o is combinational from state; it is high for exactly Iters cycles per operation.
- Reset asserted mid-RUN or mid-DONE:
  - Immediate return to IDLE; all outputs take reset values.
  - The counter shares rst_i, so the index restarts at 0.
  - The in-flight result is discarded.
- last_i is sampled only in RUN.

## Test plan

- Reset: assert rst_i mid-cycle → in_ready_o=1, out_valid_o=0, cnt_ena_o=0, x_o/y_o/z_o=0 immediately, without waiting for a clock edge.
- Width=16, Iters=16; x=9950, y=0, z=0 → out_valid_o exactly 16 edges after accept; x_o=16384±4, y_o=0±4, z_o=0±4; cnt_ena_o high for 16 cycles.
- x=9950, y=0, z=12868 (π/4) → x_o=11585±4, y_o=11585±4.
- x=9950, y=0, z=-25736 (-π/2) → x_o=0±4, y_o=-16384±4.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE while pulsing in_valid_i → outputs stable, in_ready_o=0, no capture. After the out_ready_i handshake, in_ready_o=1 next cycle and a back-to-back operand gives correct results.
- Assert rst_i during RUN at iter_i=7 → all outputs reset. The next operation (x=9950, y=0, z=0) completes in 16 cycles with x_o=16384±4.
